// File: rtl/uart_result_serializer.sv
// Splits a captured ALU result into DATA_BITS-wide bytes, LSB first, for the UART transmitter.
// Optional trailing XOR checksum byte when RESULT_SERIALIZER_CHECKSUM_EN is defined.
module uart_result_serializer #(
  parameter int NB_RESULT = 16,
  parameter int DATA_BITS = 8
) (
  input  logic                 i_clk,
  input  logic                 i_reset,
  input  logic                 i_start,
  input  logic [NB_RESULT-1:0] i_result,
  input  logic                 i_tx_busy,
  input  logic                 i_tx_done,
  output logic                 o_tx_start,
  output logic [DATA_BITS-1:0] o_tx_data,
  output logic                 o_busy,
  output logic                 o_done,
  output logic                 o_dropped
);
  localparam int NUM_BYTES = NB_RESULT / DATA_BITS;
  localparam int IDX_W     = $clog2(NUM_BYTES + 1);
`ifdef RESULT_SERIALIZER_CHECKSUM_EN
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_BYTES);

  function automatic logic [DATA_BITS-1:0] xor_bytes(input logic [NB_RESULT-1:0] v);
    logic [DATA_BITS-1:0] acc;
    acc = '0;
    for (int b = 0; b < NUM_BYTES; b++) acc = acc ^ v[b*DATA_BITS +: DATA_BITS];
    return acc;
  endfunction
`else
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_BYTES - 1);
`endif

  typedef enum logic [1:0] {ST_IDLE, ST_SEND, ST_WAIT_DONE} state_t;

  state_t               r_state, w_state_nx;
  logic [IDX_W-1:0]     r_index, w_index_nx;
  logic [NB_RESULT-1:0] r_shadow, w_shadow_nx;
  logic                 r_tx_start, w_tx_start_nx;
  logic [DATA_BITS-1:0] r_tx_data, w_tx_data_nx;
  logic                 r_done, w_done_nx;
  logic                 r_dropped, w_dropped_nx;
  logic [DATA_BITS-1:0] w_byte;

  // Byte currently addressed by the index; the slot past the data bytes is the checksum.
  always_comb begin
    w_byte = '0;
    for (int b = 0; b < NUM_BYTES; b++)
      if (r_index == IDX_W'(b)) w_byte = r_shadow[b*DATA_BITS +: DATA_BITS];
`ifdef RESULT_SERIALIZER_CHECKSUM_EN
    if (r_index == IDX_W'(NUM_BYTES)) w_byte = xor_bytes(r_shadow);
`endif
  end

  always_comb begin
    w_state_nx    = r_state;
    w_index_nx    = r_index;
    w_shadow_nx   = r_shadow;
    w_tx_start_nx = 1'b0;
    w_tx_data_nx  = r_tx_data;
    w_done_nx     = 1'b0;
    w_dropped_nx  = 1'b0;
    if (i_start && (r_state != ST_IDLE)) w_dropped_nx = 1'b1;
    case (r_state)
      ST_IDLE: begin
        if (i_start) begin
          w_shadow_nx = i_result;
          w_index_nx  = '0;
          w_state_nx  = ST_SEND;
        end
      end
      ST_SEND: begin
        if (!i_tx_busy) begin
          w_tx_start_nx = 1'b1;
          w_tx_data_nx  = w_byte;
          w_state_nx    = ST_WAIT_DONE;
        end
      end
      ST_WAIT_DONE: begin
        if (i_tx_done) begin
          if (r_index == LAST_IDX) begin
            w_state_nx = ST_IDLE;
            w_done_nx  = 1'b1;
          end else begin
            w_index_nx = r_index + IDX_W'(1);
            w_state_nx = ST_SEND;
          end
        end
      end
      default: w_state_nx = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state    <= ST_IDLE;
      r_index    <= '0;
      r_shadow   <= '0;
      r_tx_start <= 1'b0;
      r_tx_data  <= '0;
      r_done     <= 1'b0;
      r_dropped  <= 1'b0;
    end else begin
      r_state    <= w_state_nx;
      r_index    <= w_index_nx;
      r_shadow   <= w_shadow_nx;
      r_tx_start <= w_tx_start_nx;
      r_tx_data  <= w_tx_data_nx;
      r_done     <= w_done_nx;
      r_dropped  <= w_dropped_nx;
    end
  end

  assign o_tx_start = r_tx_start;
  assign o_tx_data  = r_tx_data;
  assign o_busy     = (r_state != ST_IDLE);
  assign o_done     = r_done;
  assign o_dropped  = r_dropped;
endmodule

// File: tb/tb_uart_result_serializer.sv
// Bench for uart_result_serializer: table of result transfers against a simple UART transmitter model,
// plus hand-written reset sequences. Build with RESULT_SERIALIZER_CHECKSUM_EN to expect the XOR byte.
module tb_uart_result_serializer;
`ifdef RESULT_SERIALIZER_CHECKSUM_EN
  localparam int NB = 3;
`else
  localparam int NB = 2;
`endif

  logic        i_clk = 1'b0;
  logic        i_reset = 1'b1;
  logic        i_start = 1'b0;
  logic [15:0] i_result = '0;
  logic        i_tx_busy;
  logic        i_tx_done;
  logic        o_tx_start;
  logic [7:0]  o_tx_data;
  logic        o_busy;
  logic        o_done;
  logic        o_dropped;

  uart_result_serializer #(.NB_RESULT(16), .DATA_BITS(8)) dut (
    .i_clk(i_clk), .i_reset(i_reset), .i_start(i_start), .i_result(i_result),
    .i_tx_busy(i_tx_busy), .i_tx_done(i_tx_done), .o_tx_start(o_tx_start),
    .o_tx_data(o_tx_data), .o_busy(o_busy), .o_done(o_done), .o_dropped(o_dropped)
  );

  always #5 i_clk = ~i_clk;

  // Transmitter model: busy for 10 cycles after each start, then a one-cycle done.
  logic model_en = 1'b1;
  logic hold_busy = 1'b0;
  logic stray_done = 1'b0;
  logic tx_busy_m = 1'b0;
  logic tx_done_m = 1'b0;
  int   tx_cnt = 0;
  assign i_tx_busy = tx_busy_m | hold_busy;
  assign i_tx_done = tx_done_m | stray_done;

  always @(negedge i_clk) begin
    tx_done_m = 1'b0;
    if (!model_en) begin
      tx_cnt    = 0;
      tx_busy_m = 1'b0;
    end else if (tx_cnt > 0) begin
      tx_cnt = tx_cnt - 1;
      if (tx_cnt == 0) begin
        tx_busy_m = 1'b0;
        tx_done_m = 1'b1;
      end
    end else if (o_tx_start) begin
      tx_busy_m = 1'b1;
      tx_cnt    = 10;
    end
  end

  // Monitor: record every transmitted byte and count done/dropped pulses.
  logic [7:0] q[$];
  int done_cnt = 0;
  int drop_cnt = 0;
  always @(negedge i_clk) begin
    if (o_tx_start) q.push_back(o_tx_data);
    if (o_done) done_cnt = done_cnt + 1;
    if (o_dropped) drop_cnt = drop_cnt + 1;
  end

  typedef struct {
    logic [15:0] result;
    int          hold;
    bit          drop;
    logic [15:0] drop_val;
    bit          chain;
    logic [7:0]  b0;
    logic [7:0]  b1;
    logic [7:0]  ck;
  } vec_t;
  vec_t tbl[5];

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic pulse_start(input logic [15:0] val);
    @(negedge i_clk);
    i_start  = 1'b1;
    i_result = val;
    @(negedge i_clk);
    i_start  = 1'b0;
  endtask

  task automatic run_vec(input int i);
    int qb, db, dropb, early, n;
    logic [7:0] exp_b[3];
    exp_b[0] = tbl[i].b0;
    exp_b[1] = tbl[i].b1;
    exp_b[2] = tbl[i].ck;
    qb = q.size();
    db = done_cnt;
    dropb = drop_cnt;
    early = 0;
    if (tbl[i].hold > 0) hold_busy = 1'b1;
    if (!tbl[i].chain) pulse_start(tbl[i].result);
    for (int c = 0; c < tbl[i].hold; c++) begin
      if (o_tx_start) early++;
      @(negedge i_clk);
    end
    hold_busy = 1'b0;
    chk("no_early_start", early, 0);
    @(negedge i_clk);
    chk("first_start_latency", o_tx_start, 1'b1);
    if (tbl[i].drop) begin
      pulse_start(tbl[i].drop_val);
      chk("dropped_pulse", o_dropped, 1'b1);
      @(negedge i_clk);
      chk("dropped_one_cycle", o_dropped, 1'b0);
    end
    n = 0;
    while (!o_done && n < 200) begin
      @(negedge i_clk);
      n++;
    end
    chk("done_seen", o_done, 1'b1);
    chk("busy_low_in_done", o_busy, 1'b0);
    chk("byte_count", q.size() - qb, NB);
    for (int b = 0; b < NB; b++)
      if (qb + b < q.size()) chk($sformatf("byte%0d_vec%0d", b, i), q[qb+b], exp_b[b]);
    chk("drop_count", drop_cnt - dropb, tbl[i].drop);
    if (i + 1 < 5 && tbl[i+1].chain) begin
      i_start  = 1'b1;
      i_result = tbl[i+1].result;
      @(negedge i_clk);
      i_start  = 1'b0;
    end else begin
      repeat (5) @(negedge i_clk);
      chk("single_done", done_cnt - db, 1);
      chk("busy_after", o_busy, 1'b0);
    end
  endtask

  initial begin
    int qb, db;
    tbl[0] = '{16'h1234, 0,  1'b0, 16'h0000, 1'b0, 8'h34, 8'h12, 8'h26};
    tbl[1] = '{16'h00FF, 20, 1'b0, 16'h0000, 1'b0, 8'hFF, 8'h00, 8'hFF};
    tbl[2] = '{16'h1234, 0,  1'b1, 16'hABCD, 1'b0, 8'h34, 8'h12, 8'h26};
    tbl[3] = '{16'hBEEF, 0,  1'b0, 16'h0000, 1'b1, 8'hEF, 8'hBE, 8'h51};
    tbl[4] = '{16'hA5C3, 0,  1'b0, 16'h0000, 1'b0, 8'hC3, 8'hA5, 8'h66};

    repeat (3) @(negedge i_clk);
    i_reset = 1'b0;
    chk("rst_tx_start", o_tx_start, 1'b0);
    chk("rst_tx_data", o_tx_data, 8'h00);
    chk("rst_busy", o_busy, 1'b0);
    chk("rst_done", o_done, 1'b0);
    chk("rst_dropped", o_dropped, 1'b0);

    for (int i = 0; i < 5; i++) run_vec(i);

    // Reset in WAIT_DONE of byte 0, then a stray done from the transmitter.
    qb = q.size();
    db = done_cnt;
    pulse_start(16'h1234);
    @(negedge i_clk);
    chk("abort_first_start", o_tx_start, 1'b1);
    repeat (3) @(negedge i_clk);
    i_reset  = 1'b1;
    model_en = 1'b0;
    @(negedge i_clk);
    i_reset = 1'b0;
    chk("abort_tx_start", o_tx_start, 1'b0);
    chk("abort_tx_data", o_tx_data, 8'h00);
    chk("abort_busy", o_busy, 1'b0);
    stray_done = 1'b1;
    @(negedge i_clk);
    stray_done = 1'b0;
    repeat (20) @(negedge i_clk);
    chk("abort_no_done", done_cnt - db, 0);
    chk("abort_bytes", q.size() - qb, 1);
    chk("abort_idle", o_busy, 1'b0);
    model_en = 1'b1;

    // Start coinciding with reset: reset wins.
    i_reset  = 1'b1;
    i_start  = 1'b1;
    i_result = 16'h5555;
    @(negedge i_clk);
    i_reset = 1'b0;
    i_start = 1'b0;
    repeat (3) @(negedge i_clk);
    chk("rst_start_busy", o_busy, 1'b0);
    chk("rst_start_bytes", q.size() - qb, 1);

    // Recovery after the abort.
    run_vec(0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, expected completion");
    $fatal(1);
  end
endmodule

// File: doc/uart_result_serializer.md
Name: uart_result_serializer

Overview:
- Downstream of the ALU, upstream of the UART transmitter.
- Captures the full NB_RESULT-bit ALU result on a start pulse and sends it as consecutive DATA_BITS-wide bytes, least-significant byte first.
- Handshakes with the transmitter through its start pulse, busy flag and done pulse.
- Replaces the current path, which sends only the 8 LSBs of the result.

Parameters:
- NB_RESULT, 16, width of the ALU result; must be an integer multiple of DATA_BITS.
- DATA_BITS, 8, width of one UART byte.
- NUM_BYTES (localparam), NB_RESULT/DATA_BITS, number of data bytes per result.

Ports:
- i_clk  in  1  system clock; all logic on the rising edge.
- i_reset  in  1  reset; synchronous, active-high.
- i_start  in  1  one-cycle pulse; latch i_result and begin a transfer.
- i_result  in  NB_RESULT  ALU result; sampled only when i_start is accepted.
- i_tx_busy  in  1  transmitter busy (its o_tx_transmiting).
- i_tx_done  in  1  transmitter one-cycle done pulse (its o_tx_done).
- o_tx_start  out  1  one-cycle start pulse to the transmitter.
- o_tx_data  out  DATA_BITS  byte to transmit.
- o_busy  out  1  transfer in progress.
- o_done  out  1  one-cycle pulse when the final byte has completed.
- o_dropped  out  1  one-cycle pulse when i_start is ignored.

Behaviour:
- Reset: all outputs 0, state IDLE, byte index 0, shadow register 0. Reset applied mid-transfer aborts it: no further o_tx_start, and no o_done for the aborted transfer.
- FSM states: IDLE, SEND, WAIT_DONE.
- IDLE:
  - When i_start is sampled high, capture i_result into the shadow register, set index=0, go to SEND.
  - i_tx_done is ignored in IDLE.
- SEND:
  - If i_tx_busy is sampled low: o_tx_start=1 for the next cycle only, o_tx_data=shadow[index*DATA_BITS +: DATA_BITS], go to WAIT_DONE.
  - If i_tx_busy is high: stay in SEND, no pulse.
  - i_tx_done is ignored in SEND.
- WAIT_DONE: on i_tx_done:
  - If index==last: go to IDLE and pulse o_done in the first IDLE cycle.
  - Otherwise: index+1, go to SEND.
- Outputs are registered.
- Latency, uncontended path: i_start sampled at edge N (with i_tx_busy low at edge N+1) gives o_tx_start high in the cycle after edge N+1.
- o_tx_data is stable from the o_tx_start cycle until the edge that samples the corresponding i_tx_done.
- o_busy is high in SEND and WAIT_DONE only. It is low in the o_done cycle.
- An i_start sampled in the o_done cycle is accepted as a new transfer (back-to-back).
- i_start sampled while o_busy=1: ignored, shadow unchanged, o_dropped=1 in the next cycle.
- i_start and i_reset together: reset wins.
- Index width is clog2(NUM_BYTES+1). Index wraps only by returning to IDLE, never arithmetically.

Optional Feature:
- Macro: RESULT_SERIALIZER_CHECKSUM_EN
- Defined: after the last data byte, one extra byte is sent, equal to the XOR of all NUM_BYTES data bytes of the captured result. It uses the same SEND/WAIT_DONE handshake. o_done pulses after that byte's i_tx_done.
- Undefined: exactly NUM_BYTES bytes per transfer, and no checksum logic is synthesized.

Test Plan:
- Reset, then i_start with i_result=0x1234; transmitter model asserts busy for 10 cycles, then pulses done. Required: o_tx_start twice, bytes 0x34 then 0x12, one o_done after the second done, o_busy low afterwards.
- i_tx_busy held high when i_start=0x00FF arrives, released 20 cycles later. Required: no o_tx_start until the cycle after busy is sampled low; first byte 0xFF, then 0x00.
- Second i_start=0xABCD during an active 0x1234 transfer. Required: o_dropped pulse; the transfer still sends 0x34, 0x12; 0xABCD is never sent.
- i_start=0xBEEF in the same cycle as o_done of the previous transfer. Required: accepted; bytes 0xEF, 0xBE follow with no gap beyond the handshake.
- i_reset asserted for one cycle in WAIT_DONE of byte 0, then a stray i_tx_done. Required: all outputs 0, no o_done, stay in IDLE.
- With RESULT_SERIALIZER_CHECKSUM_EN defined, i_result=0x1234. Required: bytes 0x34, 0x12, 0x26 (checksum), then o_done once.
